// File: rtl/portb_uart_pkg.sv
// Shared types and constants for the port-B UART transmitter.
package portb_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [6:0] PORTB_ADDR = 7'h0d;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO; pushes into a full FIFO are ignored, pops from an empty one too.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a same-edge pop never makes room for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/portb_uart_tx.sv
// Buffers CPU port-B writes and serializes each byte as an 8N1 UART frame on tx.
module portb_uart_tx
  import portb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_t state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  fifo_dout;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bit_end;

  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);
  assign full     = fifo_full;
  assign empty    = fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A dropped write beats a same-cycle clear so the loss is never hidden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                overflow <= 1'b0;
    else if (wr_en && full)    overflow <= 1'b1;
    else if (clr_ovf)          overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        // tx is loaded one bit ahead from shreg[1] because the shift lands on the same edge.
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
